// File: rtl/seq_detector_1011.sv
// ---------------------------------------------------------------------------
// seq_detector_1011
//   Moore-style serial pattern detector for the bit sequence 1-0-1-1, with a
//   wrapping match counter. din is expected to be the registered q output of
//   an upstream flop stage, so it is already synchronous to clk.
//
// Parameters
//   OVERLAP : 1 = the tail of a match may start the next one,
//             0 = the detector restarts clean after each match.
//   CNT_W   : width of the match counter.
//
// Ports
//   clk   : clock; all state changes on the rising edge.
//   r     : synchronous active-high reset. It overrides en and din.
//   en    : sample enable. din is consumed only on edges where en=1.
//   din   : serial data bit.
//   det   : match flag. High while the FSM is in S4.
//   cnt   : number of matches since reset, modulo 2^CNT_W.
//   state : current FSM state code, for debug.
// ---------------------------------------------------------------------------
module seq_detector_1011 #(
    parameter int OVERLAP = 1,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             r,
    input  logic             en,
    input  logic             din,
    output logic             det,
    output logic [CNT_W-1:0] cnt,
    output logic [2:0]       state
);

    // The state code equals the length of the pattern prefix seen so far.
    typedef enum logic [2:0] {
        S0 = 3'b000,   // nothing
        S1 = 3'b001,   // "1"
        S2 = 3'b010,   // "10"
        S3 = 3'b011,   // "101"
        S4 = 3'b100    // "1011" (match)
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic             det_reg;
    logic [CNT_W-1:0] cnt_reg;

    // Next-state logic. Codes 101-111 are illegal and fall back to S0.
    always_comb begin
        state_next = S0;
        case (state_reg)
            S0: state_next = din ? S1 : S0;
            S1: state_next = din ? S1 : S2;
            S2: state_next = din ? S3 : S0;
            S3: state_next = din ? S4 : S2;
            // After a match, a trailing 0 either reuses the last "1" of the
            // match (giving "10") or the detector starts over.
            S4: state_next = din ? S1 : ((OVERLAP != 0) ? S2 : S0);
            default: state_next = S0;
        endcase
    end

    // det is registered from the next state, so it is exactly (state==S4)
    // without any combinational path from din. cnt advances on the same
    // edge that enters S4; S4 has no self-loop, so each match counts once.
    always_ff @(posedge clk) begin
        if (r) begin
            state_reg <= S0;
            det_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else if (en) begin
            state_reg <= state_next;
            det_reg   <= (state_next == S4);
            if (state_next == S4) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign state = state_reg;
    assign det   = det_reg;
    assign cnt   = cnt_reg;

endmodule

// File: doc/seq_detector_1011.md
Name: seq_detector_1011

Overview:
- Serial pattern detector for the bit sequence 1-0-1-1 on a single-bit input stream; Moore FSM plus a match counter.
- Sits directly downstream of the team's positive-edge D flip-flop stage: it consumes the registered serial bit (flop q output) as din.
- State and count registers are positive-edge D flip-flops; the next-state and count logic is combinational around them.

Parameters:
- OVERLAP, 1, 1 = overlapping matches allowed (the trailing bits of one match may start the next); 0 = detector restarts clean after each match.
- CNT_W, 4, width of the match counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- r  input  1  reset; synchronous, active-high.
- en  input  1  sample enable; din is consumed only on edges where en=1.
- din  input  1  serial data bit (registered flop output from the upstream stage).
- det  output  1  Moore match flag; high while the FSM is in S4.
- cnt  output  CNT_W  number of matches since reset, modulo 2^CNT_W.
- state  output  3  current FSM state encoding, for debug and verification.

Behaviour:
- Reset: on a rising clk edge with r=1, state=S0 (000), det=0, cnt=0. r has priority over en and din. Reset mid-sequence discards partial progress.
- State encoding: S0=000 (nothing), S1=001 ("1"), S2=010 ("10"), S3=011 ("101"), S4=100 ("1011"). Codes 101–111 are illegal and go to S0 on the next enabled edge.
- Transitions, on an edge with r=0, en=1 (din=0 / din=1):
  - S0 -> S0 / S1
  - S1 -> S2 / S1
  - S2 -> S0 / S3
  - S3 -> S2 / S4
  - S4 -> S2 / S1 when OVERLAP=1; S4 -> S0 / S1 when OVERLAP=0
- Hold: with r=0, en=0, state, det and cnt hold; din is ignored.
- det = (state==S4), decoded from registered state only, so it has no combinational path from din.
  - det rises on the edge that samples the final 1 of the pattern. That is one clock of latency from the bit being presented.
  - det stays high exactly one enabled cycle, or longer if en is held low while in S4.
- cnt increments by 1 on the same edge that enters S4. cnt and det therefore update together.
  - Wrap: 2^CNT_W - 1 -> 0 with no flag or saturation.
  - S4 -> S4 is impossible, so a single match never double-counts.
- Simultaneous r=1 and en=1: reset wins, nothing is counted.

Test Plan:
1. Reset then OVERLAP=1, en=1, din stream 1,0,1,1,0,1,1 -> state S1,S2,S3,S4,S2,S3,S4; det high after bits 4 and 7 only; cnt=2 at end.
2. Same stream with OVERLAP=0 -> state S1,S2,S3,S4,S0,S1,S1; det high after bit 4 only; cnt=1.
3. Enable hold: stream 1,0,1 with en=1, then en=0 for 3 cycles with din=0, then en=1 with din=1 -> state remains S3 during the hold; det=1 and cnt=1 after the final edge.
4. Reset mid-pattern: stream 1,0,1, then r=1 for one edge, then din=1 -> state S0 after reset, then S1; det stays 0; cnt=0.
5. Counter wrap: OVERLAP=1, CNT_W=4, feed 1 followed by "011" repeated 16 times -> 16 det pulses; cnt reads 15 after the 15th match and 0 after the 16th.
6. Reset priority: in S3 with cnt=5, drive r=1, en=1, din=1 on the same edge -> state S0, det=0, cnt=0 (no match counted).
